// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO controller.
// The storage word carries an extra even-parity bit when FIFO_PARITY_EN is defined.
package fifo_pkg;

    // Widest payload the parity helper accepts; narrower words are zero-extended.
    localparam int PARITY_MAX_W = 64;

    // Registered status flags, all derived from the same next-count value.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Pointers carry one lap bit above the index bits.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Even-parity bit: makes the total number of ones in {bit, word} even.
    // Zero-extension does not change the reduction XOR.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_ctrl: synchronous write, registered read.
// The read register resets to zero so the FIFO data output starts cleared; the
// array itself is never reset. With FIFO_PARITY_EN the addressed word's parity
// is also exposed combinationally so the controller can flag a bad word on the
// same edge that the word is captured.
module sync_fifo_ram #(
    parameter int Word_Width = 8,
    parameter int Addr_Width = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [Addr_Width-1:0] waddr,
    input  logic [Word_Width-1:0] wdata,
    input  logic                  re,
    input  logic [Addr_Width-1:0] raddr,
    output logic [Word_Width-1:0] rdata
`ifdef FIFO_PARITY_EN
    ,
    output logic                  rd_word_odd
`endif
);

    localparam int Words = 1 << Addr_Width;

    logic [Word_Width-1:0] mem [Words];
    logic [Word_Width-1:0] rdata_d;
    logic [Word_Width-1:0] rdata_q;

    // Array write: contents only change on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-register next value: capture the addressed word on a read, else hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Read register with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

`ifdef FIFO_PARITY_EN
    // An odd number of ones in the stored word means the parity bit disagrees.
    assign rd_word_odd = ^mem[raddr];
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: owns pointers, occupancy count, registered
// threshold flags and sticky error flags around a sync_fifo_ram instance.
// Optional feature macro: FIFO_PARITY_EN adds a stored even-parity bit per word
// and a sticky par_err output.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int Data_Width   = 8,
    parameter int Addr_Width   = 8,
    parameter int Depth        = 256,
    parameter int Afull_Level  = 240,
    parameter int Aempty_Level = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [Data_Width-1:0] data_in,
    input  logic                  rd_en,
    output logic [Data_Width-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [Addr_Width:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
`ifdef FIFO_PARITY_EN
    ,
    output logic                  par_err
`endif
);

    localparam int PTR_W = ptr_width(Addr_Width);

`ifdef FIFO_PARITY_EN
    localparam int WORD_W = Data_Width + 1;
`else
    localparam int WORD_W = Data_Width;
`endif

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(Depth);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(Afull_Level);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(Aempty_Level);

    // Pointer arithmetic relies on natural index roll-over, so Depth must be a power of two.
    generate
        if (Depth != (1 << Addr_Width)) begin : g_depth_check
            $error("sync_fifo_ctrl: Depth (%0d) must equal 2**Addr_Width (%0d)", Depth, 1 << Addr_Width);
        end
`ifdef FIFO_PARITY_EN
        if (Data_Width > PARITY_MAX_W) begin : g_parity_width_check
            $error("sync_fifo_ctrl: Data_Width (%0d) exceeds parity helper width (%0d)", Data_Width, PARITY_MAX_W);
        end
`endif
    endgenerate

    logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d, rd_ptr_q;
    logic [PTR_W-1:0]  count_d, count_q;
    fifo_status_t      status_d, status_q;
    logic              rd_valid_d, rd_valid_q;
    logic              overflow_d, overflow_q;
    logic              underflow_d, underflow_q;
    logic              wr_acc, rd_acc;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

`ifdef FIFO_PARITY_EN
    logic              par_err_d, par_err_q;
    logic              rd_word_odd;
`endif

    // Accept decisions look only at the registered flags, so a full FIFO rejects
    // a write even when a read drains a slot on the same edge (and vice versa).
    always_comb begin
        wr_acc = wr_en & ~status_q.full;
        rd_acc = rd_en & ~status_q.empty;
    end

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + PTR_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - PTR_ONE;
        end
    end

    // Flags come from the next count so they move on the same edge as count.
    always_comb begin
        status_d.full         = (count_d == DEPTH_C);
        status_d.empty        = (count_d == '0);
        status_d.almost_full  = (count_d >= AFULL_C);
        status_d.almost_empty = (count_d <= AEMPTY_C);
    end

    // Read-valid pulse and sticky errors; a new error wins over clr_err.
    always_comb begin
        rd_valid_d  = rd_acc;
        overflow_d  = (wr_en & status_q.full)  | (overflow_q  & ~clr_err);
        underflow_d = (rd_en & status_q.empty) | (underflow_q & ~clr_err);
    end

`ifdef FIFO_PARITY_EN
    // Parity error is judged on the word being captured, so it rises with rd_valid.
    always_comb begin
        par_err_d = (rd_acc & rd_word_odd) | (par_err_q & ~clr_err);
    end
`endif

    // Control state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            status_q    <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            status_q    <= status_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_PARITY_EN
    // Sticky parity error register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign ram_wdata = {even_parity(PARITY_MAX_W'(data_in)), data_in};
    assign par_err   = par_err_q;
`else
    assign ram_wdata = data_in;
`endif

    sync_fifo_ram #(
        .Word_Width (WORD_W),
        .Addr_Width (Addr_Width)
    ) u_ram (
        .clk         (clk),
        .rstn        (rstn),
        .we          (wr_acc),
        .waddr       (wr_ptr_q[Addr_Width-1:0]),
        .wdata       (ram_wdata),
        .re          (rd_acc),
        .raddr       (rd_ptr_q[Addr_Width-1:0]),
        .rdata       (ram_rdata)
`ifdef FIFO_PARITY_EN
        ,
        .rd_word_odd (rd_word_odd)
`endif
    );

    assign data_out     = ram_rdata[Data_Width-1:0];
    assign rd_valid     = rd_valid_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // The lap bit lets the pointers alone distinguish full from empty; keep the
    // count-derived flags honest against that.
    a_full_ptrs : assert property (@(posedge clk) disable iff (!rstn)
        status_q.full == ((wr_ptr_q[Addr_Width] != rd_ptr_q[Addr_Width]) &&
                          (wr_ptr_q[Addr_Width-1:0] == rd_ptr_q[Addr_Width-1:0])));
    a_empty_ptrs : assert property (@(posedge clk) disable iff (!rstn)
        status_q.empty == (wr_ptr_q == rd_ptr_q));
    a_count_ptrs : assert property (@(posedge clk) disable iff (!rstn)
        count_q == (wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl against a queue-based reference model.
// Parity checks are compiled in only when FIFO_PARITY_EN is defined.
module tb_sync_fifo_ctrl;

    localparam int DW     = 8;
    localparam int AW     = 8;
    localparam int DEPTH  = 256;
    localparam int AFULL  = 240;
    localparam int AEMPTY = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          clr_err = 1'b0;
`ifdef FIFO_PARITY_EN
    logic          par_err;
`endif

    int errs = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_rv, m_ov, m_un, m_par;
    bit            corrupt_pending;
    int unsigned   wr_total;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .Data_Width   (DW),
        .Addr_Width   (AW),
        .Depth        (DEPTH),
        .Afull_Level  (AFULL),
        .Aempty_Level (AEMPTY)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
`ifdef FIFO_PARITY_EN
        ,
        .par_err      (par_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_rv = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
        m_par = 1'b0;
        corrupt_pending = 1'b0;
        wr_total = 0;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AFULL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
`ifdef FIFO_PARITY_EN
        chk("par_err", 32'(par_err), 32'(m_par));
`endif
    endtask

    // Apply one clock edge of FIFO rules to the model, using pre-edge occupancy.
    task automatic model_edge(input logic wr, input logic rd, input logic [DW-1:0] din, input logic clr);
        bit was_full, was_empty, bad;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        bad = 1'b0;
        if (wr && was_full) m_ov = 1'b1;
        else if (clr)       m_ov = 1'b0;
        if (rd && was_empty) m_un = 1'b1;
        else if (clr)        m_un = 1'b0;
        m_rv = rd && !was_empty;
        if (m_rv) begin
            m_dout = q.pop_front();
            if (corrupt_pending && q.size() == 0) begin
                bad = 1'b1;
                corrupt_pending = 1'b0;
            end
        end
        if (bad)      m_par = 1'b1;
        else if (clr) m_par = 1'b0;
        if (wr && !was_full) begin
            q.push_back(din);
            wr_total++;
        end
    endtask

    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din, input logic clr);
        wr_en = wr;
        rd_en = rd;
        data_in = din;
        clr_err = clr;
        @(posedge clk);
        model_edge(wr, rd, din, clr);
        #1;
        check_all();
    endtask

    initial begin
        int target;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_all();
        @(posedge clk);
        #1;

        // Small write/read burst
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Fill to full, then try one more write
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, $urandom, 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Full with simultaneous write and read: only the read is accepted
        step(1'b1, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Drain everything, verifying order
        while (q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Read while empty, then clear
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Empty with simultaneous write and read: only the write is accepted
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Streaming at count 10 across several pointer laps
        while (q.size() < 10) step(1'b1, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < 600; i++) step(1'b1, 1'b1, $urandom, 1'b0);

        // Randomised traffic with drifting bias so both extremes are visited
        for (int ph = 0; ph < 8; ph++) begin
            target = (ph % 2 == 0) ? 85 : 15;
            for (int i = 0; i < 400; i++) begin
                step(($urandom_range(99) < target), ($urandom_range(99) < (100 - target)),
                     $urandom, ($urandom_range(99) < 4));
            end
        end

        // Asynchronous reset in the middle of a write
        wr_en = 1'b1;
        rd_en = 1'b0;
        data_in = 8'h5A;
        clr_err = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, 1'b0);

`ifdef FIFO_PARITY_EN
        // Corrupt the stored parity bit of a lone word; data is still delivered
        while (q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        begin
            int idx;
            idx = int'((wr_total - 1) % DEPTH);
            dut.u_ram.mem[idx][DW] = ~dut.u_ram.mem[idx][DW];
            corrupt_pending = 1'b1;
        end
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 8'h5B, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
